// File: rtl/shift_deserializer.sv
// shift_deserializer: serial-in, parallel-out shift register with a valid/ready word output.
// Build macro DESER_PARITY_EN adds a trailing even-parity bit per word and the parity_err output.
module shift_deserializer #(
   parameter int WIDTH = 8,
   parameter int CW    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_valid,
   input  logic             bit_in,
   output logic             bit_ready,
   input  logic             msb_first,
   input  logic             flush,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef DESER_PARITY_EN
   output logic             parity_err,
`endif
   output logic [CW-1:0]    bit_count
);

`ifdef DESER_PARITY_EN
   typedef enum logic [1:0] {COLLECT, FULL, PARITY} state_t;
`else
   typedef enum logic [1:0] {COLLECT, FULL} state_t;
`endif

   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state, state_n;
   logic [WIDTH-1:0] sreg, sreg_n, out_n, shifted;
   logic [CW-1:0]    cnt_n;
   logic             order, order_n, order_eff;
   logic             accept, data_accept, last_bit;
`ifdef DESER_PARITY_EN
   logic             perr_n;
`endif

   // Handshakes: a bit moves when bit_valid && bit_ready at a rising edge; a word moves
   // when out_valid && out_ready. out/out_valid stay put until the word moves.
   assign out_valid = (state == FULL);
   assign bit_ready = !out_valid || out_ready;
   assign accept    = bit_valid && bit_ready && !flush;
`ifdef DESER_PARITY_EN
   assign data_accept = accept && (state != PARITY);
`else
   assign data_accept = accept;
`endif

   // Order is sampled live on the first bit of a word, then held for the rest of it.
   assign order_eff = (bit_count == '0) ? msb_first : order;
   assign shifted   = order_eff ? {sreg[WIDTH-2:0], bit_in} : {bit_in, sreg[WIDTH-1:1]};
   assign last_bit  = (bit_count == LAST);

   always_comb begin
      state_n = state;
      sreg_n  = sreg;
      cnt_n   = bit_count;
      out_n   = out;
      order_n = order;
`ifdef DESER_PARITY_EN
      perr_n  = parity_err;
`endif
      if (state == FULL && out_ready) state_n = COLLECT;
      if (flush) begin
         sreg_n = '0;
         cnt_n  = '0;
`ifdef DESER_PARITY_EN
         if (state == PARITY) state_n = COLLECT;
`endif
      end else if (data_accept) begin
         sreg_n  = shifted;
         order_n = order_eff;
         if (last_bit) begin
            cnt_n = '0;
`ifdef DESER_PARITY_EN
            state_n = PARITY;
`else
            out_n   = shifted;
            state_n = FULL;
`endif
         end else begin
            cnt_n = bit_count + 1'b1;
         end
      end
`ifdef DESER_PARITY_EN
      else if (accept) begin
         // Only reachable in PARITY: the extra bit closes the word.
         out_n   = sreg;
         perr_n  = ^{sreg, bit_in};
         state_n = FULL;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= COLLECT;
         sreg      <= '0;
         bit_count <= '0;
         out       <= '0;
         order     <= 1'b0;
`ifdef DESER_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         state     <= state_n;
         sreg      <= sreg_n;
         bit_count <= cnt_n;
         out       <= out_n;
         order     <= order_n;
`ifdef DESER_PARITY_EN
         parity_err <= perr_n;
`endif
      end
   end

endmodule
